line_memory: RTL
================

LINE_MEMORY -- requirements
Module: line_memory

Interface
REQ-001 Parameters SHALL be: WORD_W, 16, word width; ADDR_W, 16, word-address width; DEPTH, 256, words in array (power of 2); LINE_WORDS, 4, words per line (power of 2, divides DEPTH); LATENCY, 6, cycles from accept to response (range 2..15).
REQ-002 Ports SHALL be: clk  in  1  clock; reset_n  in  1  synchronous active-low reset.
REQ-003 Per channel c in {i, d}: c_req_valid  in  1  request present; c_req_ready  out  1  channel idle, can accept; c_req_we  in  1  1=line write, 0=line read; c_req_addr  in  ADDR_W  word address.
REQ-004 Per channel c in {i, d}: c_req_wdata  in  LINE_WORDS*WORD_W  write line, word 0 in LSBs; c_req_wmask  in  LINE_WORDS  per-word write enable; c_rsp_valid  out  1  read data valid; c_rsp_rdata  out  LINE_WORDS*WORD_W  read line; c_done  out  1  operation complete (read or write).
REQ-005 No inout ports; all outputs SHALL be driven at all times (no Z).

Function
REQ-006 Channels i and d SHALL be independent, each with its own latency counter, sharing one DEPTH x WORD_W array.
REQ-007 Accept SHALL occur on an edge where c_req_valid && c_req_ready; we, addr, wdata and wmask SHALL be captured at accept and ignored thereafter until the next accept.
REQ-008 c_req_ready SHALL equal (counter == 0); counter SHALL load LATENCY-1 on accept and decrement each cycle while nonzero.
REQ-009 Line base SHALL be addr with the low log2(LINE_WORDS) bits cleared, then taken modulo DEPTH; addresses >= DEPTH wrap.
REQ-010 Array access SHALL happen on the edge where counter goes 1->0; for reads all LINE_WORDS words SHALL be latched into c_rsp_rdata; for writes each word j with wmask[j]=1 SHALL be written, words with wmask[j]=0 SHALL stay unchanged.
REQ-011 For accept at edge k, c_done SHALL be high for exactly the cycle following edge k+LATENCY-1, and c_rsp_valid likewise for reads only; c_req_ready SHALL be high in that same cycle, permitting back-to-back accept with throughput one op per LATENCY cycles.
REQ-012 c_rsp_rdata SHALL hold its value until the next read completion on that channel.
REQ-013 Same-edge completion on both channels to the same line: a read SHALL return pre-write contents; two writes SHALL both apply, d winning per word where both masks are set.
REQ-014 A request with c_req_valid low SHALL leave the channel idle; valid during busy SHALL be ignored (not queued).

Reset
REQ-015 While reset_n=0 at an edge: counters=0, c_req_ready=1 after that edge, c_rsp_valid=0, c_done=0, c_rsp_rdata=0, captured request cleared.
REQ-016 Reset mid-operation SHALL abort the operation: no array write, no response.
REQ-017 Array contents SHALL NOT be modified by reset (preloaded by the bench).

Configuration
REQ-018 Macro LINE_MEMORY_WMASK_EN: defined -> c_req_wmask honoured per REQ-010; undefined -> c_req_wmask ignored, every write updates all LINE_WORDS words.

Verification
REQ-019 Preload words 0x20..0x23 = 0x1111,0x2222,0x3333,0x4444; i read addr 0x22 accepted at edge 0 -> i_rsp_valid/i_done high only after edge 5, i_rsp_rdata=0x4444_3333_2222_1111, i_req_ready low after edges 0..4.
REQ-020 d write addr 0x41, wdata=0xDDDD_CCCC_BBBB_AAAA, wmask=4'b0101, over old 0 -> d read 0x40 returns 0x0000_CCCC_0000_AAAA (macro defined); 0xDDDD_CCCC_BBBB_AAAA (undefined).
REQ-021 i read and d write (wmask=4'hF, 0x5555 per word) of line 0x10 accepted same edge -> i returns old line, subsequent i read returns 0x5555 per word.
REQ-022 d write addr 0x104 with DEPTH=256 -> words 0x04..0x07 updated; valid held continuously -> accepts exactly every 6 cycles.
REQ-023 reset_n low for one cycle at counter=2 during d write -> no d_done, target words unchanged, d_req_ready=1 next cycle.

Source files
------------

// File: rtl/line_memory.sv
// Dual-channel (i/d) line memory: fixed-latency line reads/writes over one shared word array.
// Per-word write masking is compiled in when LINE_MEMORY_WMASK_EN is defined.
module line_memory #(
  parameter int WORD_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 256,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 6
) (
  input  logic                         clk,
  input  logic                         reset_n,
  // instruction channel
  input  logic                         i_i_req_valid,
  output logic                         o_i_req_ready,
  input  logic                         i_i_req_we,
  input  logic [ADDR_W-1:0]            i_i_req_addr,
  input  logic [LINE_WORDS*WORD_W-1:0] i_i_req_wdata,
  input  logic [LINE_WORDS-1:0]        i_i_req_wmask,
  output logic                         o_i_rsp_valid,
  output logic [LINE_WORDS*WORD_W-1:0] o_i_rsp_rdata,
  output logic                         o_i_done,
  // data channel
  input  logic                         i_d_req_valid,
  output logic                         o_d_req_ready,
  input  logic                         i_d_req_we,
  input  logic [ADDR_W-1:0]            i_d_req_addr,
  input  logic [LINE_WORDS*WORD_W-1:0] i_d_req_wdata,
  input  logic [LINE_WORDS-1:0]        i_d_req_wmask,
  output logic                         o_d_rsp_valid,
  output logic [LINE_WORDS*WORD_W-1:0] o_d_rsp_rdata,
  output logic                         o_d_done
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LINE_W = LINE_WORDS * WORD_W;
  localparam int NCH    = 2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef logic [IDX_W-OFF_W-1:0] line_idx_t;

  // Channel 0 = i, channel 1 = d; d is processed last so it wins write collisions.
  logic                  w_valid   [NCH];
  logic                  w_we      [NCH];
  line_idx_t             w_line_in [NCH];
  logic [LINE_W-1:0]     w_wdata   [NCH];
  logic [LINE_WORDS-1:0] w_wmask   [NCH];
  logic                  w_ready   [NCH];
  logic                  w_fire    [NCH];
  logic [LINE_W-1:0]     w_rd_line [NCH];
  logic                  w_unused_bits;

  logic [3:0]            r_cnt       [NCH];
  logic                  r_we        [NCH];
  line_idx_t             r_line      [NCH];
  logic [LINE_W-1:0]     r_wdata     [NCH];
  logic [LINE_WORDS-1:0] r_wmask     [NCH];
  logic                  r_rsp_valid [NCH];
  logic                  r_done      [NCH];
  logic [LINE_W-1:0]     r_rdata     [NCH];
  logic [WORD_W-1:0]     r_mem       [DEPTH];

  assign w_valid[0]   = i_i_req_valid;
  assign w_valid[1]   = i_d_req_valid;
  assign w_we[0]      = i_i_req_we;
  assign w_we[1]      = i_d_req_we;
  assign w_line_in[0] = i_i_req_addr[IDX_W-1:OFF_W];
  assign w_line_in[1] = i_d_req_addr[IDX_W-1:OFF_W];
  assign w_wdata[0]   = i_i_req_wdata;
  assign w_wdata[1]   = i_d_req_wdata;

`ifdef LINE_MEMORY_WMASK_EN
  assign w_wmask[0]    = i_i_req_wmask;
  assign w_wmask[1]    = i_d_req_wmask;
  assign w_unused_bits = ^{i_i_req_addr[ADDR_W-1:IDX_W], i_i_req_addr[OFF_W-1:0],
                           i_d_req_addr[ADDR_W-1:IDX_W], i_d_req_addr[OFF_W-1:0]};
`else
  assign w_wmask[0]    = '1;
  assign w_wmask[1]    = '1;
  assign w_unused_bits = ^{i_i_req_addr[ADDR_W-1:IDX_W], i_i_req_addr[OFF_W-1:0],
                           i_d_req_addr[ADDR_W-1:IDX_W], i_d_req_addr[OFF_W-1:0],
                           i_i_req_wmask, i_d_req_wmask};
`endif

  // A channel completes on the edge where its counter steps 1 -> 0.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_ready[c] = (r_cnt[c] == 4'd0);
      w_fire[c]  = (r_cnt[c] == 4'd1);
    end
  end

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_rd_line[c] = '0;
      for (int j = 0; j < LINE_WORDS; j++)
        w_rd_line[c][j*WORD_W +: WORD_W] = r_mem[{r_line[c], OFF_W'(j)}];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so reads in this edge see pre-edge values.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (!reset_n) begin
        r_cnt[c]       <= '0;
        r_we[c]        <= 1'b0;
        r_line[c]      <= '0;
        r_wdata[c]     <= '0;
        r_wmask[c]     <= '0;
        r_rsp_valid[c] <= 1'b0;
        r_done[c]      <= 1'b0;
        r_rdata[c]     <= '0;
      end else begin
        r_done[c]      <= w_fire[c];
        r_rsp_valid[c] <= w_fire[c] && !r_we[c];
        if (w_fire[c] && !r_we[c])
          r_rdata[c] <= w_rd_line[c];
        if (w_valid[c] && w_ready[c]) begin
          r_cnt[c]   <= CNT_LOAD;
          r_we[c]    <= w_we[c];
          r_line[c]  <= w_line_in[c];
          r_wdata[c] <= w_wdata[c];
          r_wmask[c] <= w_wmask[c];
        end else if (r_cnt[c] != 4'd0) begin
          r_cnt[c] <= r_cnt[c] - 4'd1;
        end
      end
    end
  end

  // NOTE: the array has no reset; reset only gates the write enable so an aborted write never lands.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (reset_n && w_fire[c] && r_we[c]) begin
        for (int j = 0; j < LINE_WORDS; j++)
          if (r_wmask[c][j])
            r_mem[{r_line[c], OFF_W'(j)}] <= r_wdata[c][j*WORD_W +: WORD_W];
      end
    end
  end

  assign o_i_req_ready = w_ready[0];
  assign o_i_rsp_valid = r_rsp_valid[0];
  assign o_i_rsp_rdata = r_rdata[0];
  assign o_i_done      = r_done[0];
  assign o_d_req_ready = w_ready[1];
  assign o_d_rsp_valid = r_rsp_valid[1];
  assign o_d_rsp_rdata = r_rdata[1];
  assign o_d_done      = r_done[1];

endmodule
